// File: rtl/chacha20_stream_ctrl.sv
// ChaCha20 stream controller: requests keystream blocks from the core, buffers them
// and XORs them word by word onto an AXI-stream of plaintext.
module chacha20_stream_ctrl (
   input  logic          i_aclk,
   input  logic          i_aresetn,
   input  logic          i_enable,
   input  logic          i_cfg_load,
   input  logic [31:0]   i_cfg_counter,
   output logic          o_core_start,
   output logic [31:0]   o_core_counter,
   input  logic [511:0]  i_core_keystream,
   input  logic          i_core_keystream_valid,
   input  logic [31:0]   i_s_tdata,
   input  logic          i_s_tvalid,
   input  logic          i_s_tlast,
   output logic          o_s_tready,
   output logic [31:0]   o_m_tdata,
   output logic          o_m_tvalid,
   output logic          o_m_tlast,
   input  logic          i_m_tready,
   output logic          o_busy,
   output logic          o_err_wrap
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, STREAM} state_t;

   state_t              state, state_nxt;
   logic [15:0][31:0]   ks_buf;
   logic [3:0]          widx;
   logic [31:0]         counter;
   logic                in_hs, out_hs, blk_done;

   assign o_s_tready     = (state == STREAM) && (!o_m_tvalid || i_m_tready);
   assign in_hs          = o_s_tready && i_s_tvalid;
   assign out_hs         = o_m_tvalid && i_m_tready;
   assign blk_done       = in_hs && (i_s_tlast || (widx == 4'd15));
   assign o_core_start   = (state == REQ);
   assign o_busy         = (state != IDLE);
   assign o_core_counter = counter;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (i_enable && i_s_tvalid) state_nxt = REQ;
         REQ:     state_nxt = WAIT;
         WAIT:    if (i_core_keystream_valid) state_nxt = STREAM;
         STREAM: begin
            if (in_hs && i_s_tlast)          state_nxt = IDLE;
            else if (in_hs && widx == 4'd15) state_nxt = REQ;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) state <= IDLE;
      else            state <= state_nxt;
   end

   // Load and increment never collide: load is IDLE-only, increments happen in STREAM.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         counter    <= '0;
         o_err_wrap <= 1'b0;
      end else if (state == IDLE && i_cfg_load) begin
         counter    <= i_cfg_counter;
         o_err_wrap <= 1'b0;
      end else if (blk_done) begin
         counter <= counter + 32'd1;
         if (counter == 32'hFFFF_FFFF) o_err_wrap <= 1'b1;
      end
   end

   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         ks_buf <= '0;
         widx   <= '0;
      end else if (state == WAIT && i_core_keystream_valid) begin
         ks_buf <= i_core_keystream;
         widx   <= '0;
      end else if (in_hs) begin
         widx <= widx + 4'd1;
      end
   end

   // Output register reloads on every input handshake, so tready can stay high at full rate.
   always_ff @(posedge i_aclk or negedge i_aresetn) begin
      if (!i_aresetn) begin
         o_m_tdata  <= '0;
         o_m_tvalid <= 1'b0;
         o_m_tlast  <= 1'b0;
      end else if (in_hs) begin
         o_m_tdata  <= i_s_tdata ^ ks_buf[widx];
         o_m_tlast  <= i_s_tlast;
         o_m_tvalid <= 1'b1;
      end else if (out_hs) begin
         o_m_tvalid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_chacha20_stream_ctrl.sv
// Directed bench for chacha20_stream_ctrl: table of messages against a core model,
// plus hand sequences for reset state and reset during WAIT.
module tb_chacha20_stream_ctrl;

   logic          i_aclk = 1'b0;
   logic          i_aresetn;
   logic          i_enable, i_cfg_load;
   logic [31:0]   i_cfg_counter;
   logic          o_core_start;
   logic [31:0]   o_core_counter;
   logic [511:0]  ks_data;
   logic          ks_vld_m, ks_vld_inj;
   wire           i_core_keystream_valid = ks_vld_m | ks_vld_inj;
   logic [31:0]   i_s_tdata;
   logic          i_s_tvalid, i_s_tlast, o_s_tready;
   logic [31:0]   o_m_tdata;
   logic          o_m_tvalid, o_m_tlast, i_m_tready;
   logic          o_busy, o_err_wrap;

   chacha20_stream_ctrl dut (
      .i_aclk(i_aclk), .i_aresetn(i_aresetn), .i_enable(i_enable),
      .i_cfg_load(i_cfg_load), .i_cfg_counter(i_cfg_counter),
      .o_core_start(o_core_start), .o_core_counter(o_core_counter),
      .i_core_keystream(ks_data), .i_core_keystream_valid(i_core_keystream_valid),
      .i_s_tdata(i_s_tdata), .i_s_tvalid(i_s_tvalid), .i_s_tlast(i_s_tlast),
      .o_s_tready(o_s_tready), .o_m_tdata(o_m_tdata), .o_m_tvalid(o_m_tvalid),
      .o_m_tlast(o_m_tlast), .i_m_tready(i_m_tready), .o_busy(o_busy),
      .o_err_wrap(o_err_wrap)
   );

   always #5 i_aclk = ~i_aclk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string name, input logic [69:0] act, input logic [69:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ks_word(input logic [31:0] c, input int w);
      return (c * 32'h9E37_79B9) ^ (32'h0101_0101 * 32'(w + 1));
   endfunction

   function automatic logic [31:0] pt_word(input int e, input int k);
      return 32'h1357_2468 ^ {8'(e), 8'h3C, 16'(k)};
   endfunction

   // Core model: 3 cycles after a start pulse, present the keystream for the sampled counter.
   logic          model_on = 1'b0;
   logic [31:0]   starts_q[$];
   int            ks_cnt = 0;
   logic [31:0]   ks_ctr;
   initial begin ks_vld_m = 1'b0; ks_data = '0; end
   always @(negedge i_aclk) begin
      ks_vld_m = 1'b0;
      if (model_on) begin
         if (o_core_start) begin
            starts_q.push_back(o_core_counter);
            ks_ctr = o_core_counter;
            ks_cnt = 3;
         end else if (ks_cnt > 0) begin
            ks_cnt--;
            if (ks_cnt == 0) begin
               for (int w = 0; w < 16; w++) ks_data[32*w +: 32] = ks_word(ks_ctr, w);
               ks_vld_m = 1'b1;
            end
         end
      end
   end

   typedef struct {
      logic [31:0] ld;        // counter loaded with the first request
      int          n;         // message length in words
      int          stall_at;  // output word index held 5 cycles (-1 none)
      int          cfg_at;    // input word index at which a stray cfg_load 0x55 fires (-1 none)
      logic [31:0] fin;       // expected counter afterwards
      int          starts;    // expected start pulses
      logic        err;       // expected wrap flag
   } vec_t;

   vec_t vecs[7];

   task automatic run_msg(input int e, input vec_t v);
      logic [31:0] exp_q[$];
      int tx = 0, rx = 0, stall_left = 5, cyc = 0, base;
      logic cfg_done = 1'b0, prev_in = 1'b0;
      base = starts_q.size();
      @(negedge i_aclk);
      i_enable = 1'b1; i_s_tvalid = 1'b1; i_s_tdata = pt_word(e, 0); i_s_tlast = (v.n == 1);
      i_cfg_load = 1'b1; i_cfg_counter = v.ld; i_m_tready = 1'b1;
      @(negedge i_aclk);
      i_cfg_load = 1'b0;
      #1;
      chk("load_same_cycle_ctr", 70'(o_core_counter), 70'(v.ld));
      chk("load_clears_err", 70'(o_err_wrap), 70'(0));
      while (rx < v.n && cyc < 3000) begin
         cyc++;
         i_s_tvalid = (tx < v.n);
         i_s_tdata  = pt_word(e, tx);
         i_s_tlast  = (tx == v.n - 1);
         i_enable   = (tx == 0);
         i_cfg_load = 1'b0;
         if (tx == v.cfg_at && !cfg_done) begin
            i_cfg_load = 1'b1; i_cfg_counter = 32'h55; cfg_done = 1'b1;
         end
         i_m_tready = !(rx == v.stall_at && stall_left > 0 && o_m_tvalid);
         #1;
         if (prev_in) chk("first_word_latency", 70'(o_m_tvalid), 70'(1));
         if (!i_m_tready) begin
            stall_left--;
            chk("stall_tready_low", 70'(o_s_tready), 70'(0));
            if (exp_q.size() > 0) chk("stall_data_held", 70'(o_m_tdata), 70'(exp_q[0]));
         end
         if (o_m_tvalid && i_m_tready) begin
            if (exp_q.size() == 0) chk("unexpected_word", 70'(1), 70'(0));
            else begin
               chk("ct_word", 70'(o_m_tdata), 70'(exp_q.pop_front()));
               chk("ct_last", 70'(o_m_tlast), 70'(rx == v.n - 1));
            end
            rx++;
         end
         prev_in = o_s_tready && i_s_tvalid;
         if (prev_in) begin
            exp_q.push_back(pt_word(e, tx) ^ ks_word(32'(v.ld + 32'(tx / 16)), tx % 16));
            tx++;
         end
         @(negedge i_aclk);
      end
      i_cfg_load = 1'b0; i_s_tvalid = 1'b0; i_enable = 1'b0;
      #1;
      chk("msg_timeout", 70'(rx), 70'(v.n));
      chk("tvalid_cleared", 70'(o_m_tvalid), 70'(0));
      chk("back_to_idle", 70'(o_busy), 70'(0));
      chk("final_counter", 70'(o_core_counter), 70'(v.fin));
      chk("err_wrap", 70'(o_err_wrap), 70'(v.err));
      chk("start_count", 70'(starts_q.size() - base), 70'(v.starts));
      for (int i = 0; i < v.starts && base + i < starts_q.size(); i++)
         chk("start_counter", 70'(starts_q[base + i]), 70'(32'(v.ld + 32'(i))));
   endtask

   initial begin
      vecs[0] = '{32'h1,         16, -1, -1, 32'h2,  1, 1'b0};
      vecs[1] = '{32'h1,         20, -1, -1, 32'h3,  2, 1'b0};
      vecs[2] = '{32'hFFFF_FFFF,  1, -1, -1, 32'h0,  1, 1'b1};
      vecs[3] = '{32'h7,         10,  4, -1, 32'h8,  1, 1'b0};
      vecs[4] = '{32'hFFFF_FFFE, 17, -1, -1, 32'h0,  2, 1'b1};
      vecs[5] = '{32'h20,         5, -1,  2, 32'h21, 1, 1'b0};
      vecs[6] = '{32'h30,        33, 20, -1, 32'h33, 3, 1'b0};

      i_aresetn = 1'b0; i_enable = 1'b0; i_cfg_load = 1'b0; i_cfg_counter = '0;
      i_s_tdata = '0; i_s_tvalid = 1'b0; i_s_tlast = 1'b0; i_m_tready = 1'b0;
      ks_vld_inj = 1'b0;
      repeat (2) @(negedge i_aclk);
      #1;
      chk("reset_outputs", {o_core_start, o_core_counter, o_s_tready, o_m_tdata,
                            o_m_tvalid, o_m_tlast, o_busy, o_err_wrap}, 70'(0));
      @(negedge i_aclk);
      i_aresetn = 1'b1;

      // Reset while waiting on the core, then a late keystream pulse must be ignored.
      @(negedge i_aclk);
      i_enable = 1'b1; i_s_tvalid = 1'b1; i_s_tdata = 32'hDEAD_BEEF;
      i_cfg_load = 1'b1; i_cfg_counter = 32'h5; i_m_tready = 1'b1;
      @(negedge i_aclk);
      i_cfg_load = 1'b0;
      #1;
      chk("req_start_pulse", {o_core_start, o_core_counter}, 70'({1'b1, 32'h5}));
      @(negedge i_aclk);
      #1;
      chk("wait_no_start", {o_core_start, o_busy, o_s_tready}, 70'(3'b010));
      i_aresetn = 1'b0; i_enable = 1'b0; i_s_tvalid = 1'b0;
      #1;
      chk("async_reset_outputs", {o_core_start, o_core_counter, o_s_tready, o_m_tdata,
                                  o_m_tvalid, o_m_tlast, o_busy, o_err_wrap}, 70'(0));
      @(negedge i_aclk);
      i_aresetn = 1'b1;
      @(negedge i_aclk);
      ks_data = {16{32'hFFFF_FFFF}}; ks_vld_inj = 1'b1;
      @(negedge i_aclk);
      ks_vld_inj = 1'b0;
      repeat (2) @(negedge i_aclk);
      #1;
      chk("late_ks_ignored", {o_core_start, o_core_counter, o_s_tready, o_m_tdata,
                              o_m_tvalid, o_m_tlast, o_busy, o_err_wrap}, 70'(0));

      model_on = 1'b1;
      for (int e = 0; e < 7; e++) run_msg(e, vecs[e]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/chacha20_stream_ctrl.md
CHACHA20_STREAM_CTRL -- requirements
Module: chacha20_stream_ctrl

Interface
REQ-001 SHALL have ports, in order (name  direction  width  meaning):
  i_aclk  in  1  single clock, all logic on rising edge
  i_aresetn  in  1  asynchronous active-low reset
  i_enable  in  1  level; low holds block in IDLE
  i_cfg_load  in  1  one-cycle pulse; loads i_cfg_counter
  i_cfg_counter  in  32  initial block counter
  o_core_start  out  1  one-cycle start pulse to keystream core
  o_core_counter  out  32  block counter presented to core
  i_core_keystream  in  512  keystream block; word w at bits [32w+31:32w]
  i_core_keystream_valid  in  1  one-cycle pulse, keystream valid
  i_s_tdata / i_s_tvalid / i_s_tlast  in  32/1/1  plaintext AXI-stream slave
  o_s_tready  out  1  slave ready
  o_m_tdata / o_m_tvalid / o_m_tlast  out  32/1/1  ciphertext AXI-stream master
  i_m_tready  in  1  master ready
  o_busy  out  1  high in any state except IDLE
  o_err_wrap  out  1  sticky counter-wrap flag

Function
REQ-002 SHALL implement FSM states IDLE, REQ, WAIT, STREAM.
REQ-003 IDLE->REQ when i_enable=1 and i_s_tvalid=1; otherwise remain in IDLE.
REQ-004 REQ: assert o_core_start for exactly one cycle, then go to WAIT.
REQ-005 WAIT: on i_core_keystream_valid=1, capture all 512 bits into the internal 16x32 buffer, set word index to 0, and go to STREAM.
REQ-006 WAIT: o_core_start SHALL stay 0, and valid pulses arriving in any other state SHALL be ignored.
REQ-007 o_s_tready = (state==STREAM) and (o_m_tvalid==0 or i_m_tready==1).
REQ-008 On input handshake: o_m_tdata <= i_s_tdata XOR buffer[word index]; o_m_tlast <= i_s_tlast; o_m_tvalid <= 1; word index +1.
REQ-009 o_m_tvalid SHALL clear on output handshake with no simultaneous input handshake; o_m_tdata/o_m_tlast SHALL hold while o_m_tvalid=1 and i_m_tready=0.
REQ-010 Handshake on word 15 with i_s_tlast=0: counter +1, go to REQ.
REQ-011 Handshake with i_s_tlast=1 (any word index): counter +1, discard remaining buffer words, go to IDLE.
REQ-012 Counter arithmetic is mod 2^32; an increment from 0xFFFFFFFF SHALL give 0x00000000 and set o_err_wrap.
REQ-013 o_err_wrap SHALL clear only on i_cfg_load or reset.
REQ-014 i_cfg_load SHALL be honoured only in IDLE: counter <= i_cfg_counter, o_err_wrap <= 0. It SHALL be ignored in other states.
REQ-015 If i_cfg_load coincides with the IDLE->REQ transition, the loaded value SHALL be used by that request.
REQ-016 i_enable deassertion SHALL take effect only in IDLE; an in-progress message completes.
REQ-017 o_core_counter SHALL equal the internal counter at all times and SHALL be stable from REQ until the next counter update.
REQ-018 Latency: first ciphertext word is valid 1 cycle after the first input handshake.
REQ-019 At full rate, throughput is one word per cycle within a block, with a core-latency bubble between blocks.

Reset
REQ-020 Asynchronous reset SHALL force: state IDLE, counter 0, word index 0, buffer 0, and all outputs 0 (o_core_start, o_core_counter, o_s_tready, o_m_tdata, o_m_tvalid, o_m_tlast, o_busy, o_err_wrap).
REQ-021 Reset asserted mid-block SHALL abandon the block, and any keystream pulse arriving after release SHALL be ignored (state is IDLE).

Verification
REQ-022 Load counter 1, stream 16 words ending in tlast with core model -> one start pulse with o_core_counter=1; each output word = input XOR keystream word w; final counter 2; return to IDLE.
REQ-023 Stream 20 words with tlast on word 20 -> two start pulses (counters 1 and 2); words 17-20 use block 2 words 0-3; final counter 3.
REQ-024 Load 0xFFFFFFFF, send 1-word message with tlast -> counter 0x00000000 and o_err_wrap=1; a following i_cfg_load clears it.
REQ-025 Hold i_m_tready=0 for 5 cycles mid-block -> o_s_tready=0, output word held stable, no word lost or duplicated.
REQ-026 Assert i_aresetn=0 during WAIT, then release and inject i_core_keystream_valid -> stays IDLE, all outputs 0.
REQ-027 Pulse i_cfg_load during STREAM with 0x55 -> ignored; counter continues from the prior value.
